// File: rtl/sifre_serilestirici_if.sv
// sifre_serilestirici_if: ciphertext-in / byte-stream-out bundle for the serializer
interface sifre_serilestirici_if;
  logic [127:0] sifre;
  logic         c_gecerli;
  logic [7:0]   bayt;
  logic         bayt_gecerli;
  logic         bayt_hazir;
  logic         mesgul;
  logic         tasma;
  logic [7:0]   blok_sayisi;
  modport master (
    output sifre, c_gecerli, bayt_hazir,
    input  bayt, bayt_gecerli, mesgul, tasma, blok_sayisi
  );
  modport slave (
    input  sifre, c_gecerli, bayt_hazir,
    output bayt, bayt_gecerli, mesgul, tasma, blok_sayisi
  );
endinterface

// File: rtl/sifre_serilestirici.sv
// sifre_serilestirici: AES block to MSB-first byte stream; define SIFRE_SERILESTIRICI_FIFO_EN for a two-entry buffer
module sifre_serilestirici (
  input logic clk,
  input logic rst,
  sifre_serilestirici_if.slave s
);
  typedef enum logic {BOS, GONDER} durum_t;
  durum_t       durum;
  logic         c_q;
  logic [3:0]   k, kn;
  logic [1:0]   cnt;
  logic [127:0] cur, sonraki;
  logic         yakala, aktar, son, kabul;
`ifdef SIFRE_SERILESTIRICI_FIFO_EN
  localparam logic [1:0] DERINLIK = 2'd2;
  logic [127:0] mem [2];
  logic         wp, rp;
  assign cur     = mem[rp];
  assign sonraki = cnt == 2'd2 ? mem[~rp] : s.sifre;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= 1'b0;
      rp <= 1'b0;
    end else begin
      if (kabul) begin
        mem[wp] <= s.sifre;
        wp      <= ~wp;
      end
      if (son) rp <= ~rp;
    end
  end
`else
  localparam logic [1:0] DERINLIK = 2'd1;
  logic [127:0] mem;
  assign cur     = mem;
  assign sonraki = s.sifre;
  always_ff @(posedge clk) begin
    if (kabul) mem <= s.sifre;
  end
`endif
  assign yakala   = s.c_gecerli & ~c_q;
  assign aktar    = s.bayt_gecerli & s.bayt_hazir;
  assign son      = aktar & (k == 4'hf);
  // an entry released by the final byte this cycle is already free for a capture
  assign kabul    = yakala & ((cnt != DERINLIK) | son);
  assign kn       = k + 4'd1;
  assign s.mesgul = cnt != 2'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      durum          <= BOS;
      s.bayt_gecerli <= 1'b0;
      s.bayt         <= 8'h00;
      s.tasma        <= 1'b0;
      s.blok_sayisi  <= 8'h00;
      cnt            <= 2'd0;
      k              <= 4'd0;
      c_q            <= 1'b1;
    end else begin
      c_q <= s.c_gecerli;
      cnt <= cnt + {1'b0, kabul} - {1'b0, son};
      if (yakala & ~kabul) s.tasma <= 1'b1;
      if (durum == BOS) begin
        if (kabul) begin
          durum          <= GONDER;
          s.bayt_gecerli <= 1'b1;
          s.bayt         <= s.sifre[127:120];
          k              <= 4'd0;
        end
      end else if (aktar) begin
        if (!son) begin
          k      <= kn;
          s.bayt <= cur[{~kn, 3'b000} +: 8];
        end else begin
          k             <= 4'd0;
          s.blok_sayisi <= s.blok_sayisi + 8'd1;
          if (cnt == 2'd2 || kabul) s.bayt <= sonraki[127:120];
          else begin
            durum          <= BOS;
            s.bayt_gecerli <= 1'b0;
          end
        end
      end
    end
  end
endmodule
